// File: rtl/skel_pkg.sv
// Shared types and default geometry for the mask downsampler / skeletonizer pipeline.
package skel_pkg;

  localparam int DEFAULT_SCALE            = 4;
  localparam int DEFAULT_HORIZONTAL_COUNT = 320;
  localparam int DEFAULT_VERTICAL_COUNT   = 180;
  localparam int DEFAULT_THRESHOLD        = 8;
  localparam int HWIDTH                   = $clog2(DEFAULT_HORIZONTAL_COUNT);
  localparam int VWIDTH                   = $clog2(DEFAULT_VERTICAL_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DROP   = 2'd2
  } ds_state_t;

endpackage

// File: rtl/tile_vote_accumulator.sv
// Per-column tile accumulators: read-add-write for interior pixels, vote-and-emit on the
// last pixel of each SCALE x SCALE tile, plus a clear-all used when a frame is aborted.
module tile_vote_accumulator
  import skel_pkg::*;
#(
  parameter int SCALE     = DEFAULT_SCALE,
  parameter int COLS      = DEFAULT_HORIZONTAL_COUNT,
  parameter int ROWS      = DEFAULT_VERTICAL_COUNT,
  parameter int THRESHOLD = DEFAULT_THRESHOLD
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    clear_all_in,
  input  logic                    process_in,
  input  logic                    tile_last_in,
  input  logic                    mask_in,
  input  logic [$clog2(COLS)-1:0] col_in,
  input  logic [$clog2(ROWS)-1:0] row_in,
  output logic                    pixel_out,
  output logic [$clog2(COLS)-1:0] hcount_out,
  output logic [$clog2(ROWS)-1:0] vcount_out,
  output logic                    pixel_valid_out
);

  localparam int AW = $clog2(SCALE * SCALE + 1);
  localparam logic [AW-1:0] THR = AW'(THRESHOLD);

  logic [AW-1:0] acc_r [COLS];
  logic [AW-1:0] base_s;
  logic [AW-1:0] sum_s;

  // Aborted frames restart from zero, so the pixel that triggers the clear adds onto 0.
  always_comb begin
    if (clear_all_in) begin
      base_s = {AW{1'b0}};
    end else begin
      base_s = acc_r[col_in];
    end
    sum_s = base_s + {{(AW-1){1'b0}}, mask_in};
  end

  // Accumulator array update and registered vote output.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < COLS; i++) acc_r[i] <= {AW{1'b0}};
      pixel_out       <= 1'b0;
      hcount_out      <= {$clog2(COLS){1'b0}};
      vcount_out      <= {$clog2(ROWS){1'b0}};
      pixel_valid_out <= 1'b0;
    end else begin
      if (clear_all_in) begin
        for (int i = 0; i < COLS; i++) acc_r[i] <= {AW{1'b0}};
      end
      if (process_in && tile_last_in) begin
        acc_r[col_in]   <= {AW{1'b0}};
        pixel_out       <= (sum_s >= THR);
        hcount_out      <= col_in;
        vcount_out      <= row_in;
        pixel_valid_out <= 1'b1;
      end else begin
        if (process_in) begin
          acc_r[col_in] <= sum_s;
        end
        pixel_valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mask_downsampler.sv
// Block-majority downsampler with whole-frame gating on skeletonizer busy.
// Optional dropped-frame counter enabled by defining MASK_DOWNSAMPLER_STATS_EN.
module mask_downsampler
  import skel_pkg::*;
#(
  parameter int SCALE            = DEFAULT_SCALE,
  parameter int HORIZONTAL_COUNT = DEFAULT_HORIZONTAL_COUNT,
  parameter int VERTICAL_COUNT   = DEFAULT_VERTICAL_COUNT,
  parameter int THRESHOLD        = DEFAULT_THRESHOLD
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic [$clog2(HORIZONTAL_COUNT*SCALE)-1:0] hcount_in,
  input  logic [$clog2(VERTICAL_COUNT*SCALE)-1:0]   vcount_in,
  input  logic                                     mask_in,
  input  logic                                     mask_valid_in,
  input  logic                                     skel_busy_in,
  output logic                                     pixel_out,
  output logic [$clog2(HORIZONTAL_COUNT)-1:0]       hcount_out,
  output logic [$clog2(VERTICAL_COUNT)-1:0]         vcount_out,
  output logic                                     pixel_valid_out,
  output logic                                     frame_active_out,
  output logic [15:0]                              frames_dropped_out
);

  localparam int IN_H  = HORIZONTAL_COUNT * SCALE;
  localparam int IN_V  = VERTICAL_COUNT * SCALE;
  localparam int IHW   = $clog2(IN_H);
  localparam int IVW   = $clog2(IN_V);
  localparam int LOG2S = $clog2(SCALE);

  localparam logic [IHW:0]       IN_H_L   = (IHW+1)'(IN_H);
  localparam logic [IVW:0]       IN_V_L   = (IVW+1)'(IN_V);
  localparam logic [IHW-1:0]     H_LAST   = IHW'(IN_H - 1);
  localparam logic [IVW-1:0]     V_LAST   = IVW'(IN_V - 1);
  localparam logic [LOG2S-1:0]   SUB_LAST = LOG2S'(SCALE - 1);

  ds_state_t state_r;
  logic      frame_active_r;
  logic      pix_ok_s;
  logic      first_s;
  logic      last_s;
  logic      tile_last_s;
  logic      clear_s;
  logic      process_s;

  // Pixel classification; a (0,0) pixel always restarts the frame decision.
  always_comb begin
    pix_ok_s    = mask_valid_in && ({1'b0, hcount_in} < IN_H_L) && ({1'b0, vcount_in} < IN_V_L);
    first_s     = (hcount_in == {IHW{1'b0}}) && (vcount_in == {IVW{1'b0}});
    last_s      = (hcount_in == H_LAST) && (vcount_in == V_LAST);
    tile_last_s = (hcount_in[LOG2S-1:0] == SUB_LAST) && (vcount_in[LOG2S-1:0] == SUB_LAST);
    clear_s     = pix_ok_s && first_s;
    if (!pix_ok_s) begin
      process_s = 1'b0;
    end else if (first_s) begin
      process_s = !skel_busy_in;
    end else begin
      process_s = (state_r == ACCEPT);
    end
  end

  // Frame gating FSM; busy is only consulted on the first pixel of a frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r        <= IDLE;
      frame_active_r <= 1'b0;
    end else if (pix_ok_s) begin
      if (first_s) begin
        if (skel_busy_in) begin
          state_r        <= DROP;
          frame_active_r <= 1'b0;
        end else begin
          state_r        <= ACCEPT;
          frame_active_r <= 1'b1;
        end
      end else begin
        case (state_r)
          ACCEPT, DROP: begin
            if (last_s) begin
              state_r        <= IDLE;
              frame_active_r <= 1'b0;
            end
          end
          default: begin
            state_r        <= IDLE;
            frame_active_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign frame_active_out = frame_active_r;

  tile_vote_accumulator #(
    .SCALE     (SCALE),
    .COLS      (HORIZONTAL_COUNT),
    .ROWS      (VERTICAL_COUNT),
    .THRESHOLD (THRESHOLD)
  ) u_acc (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .clear_all_in    (clear_s),
    .process_in      (process_s),
    .tile_last_in    (tile_last_s),
    .mask_in         (mask_in),
    .col_in          (hcount_in[IHW-1:LOG2S]),
    .row_in          (vcount_in[IVW-1:LOG2S]),
    .pixel_out       (pixel_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .pixel_valid_out (pixel_valid_out)
  );

`ifdef MASK_DOWNSAMPLER_STATS_EN
  logic [15:0] dropped_r;

  // Saturating count of frames refused because the skeletonizer was busy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dropped_r <= 16'h0000;
    end else if (clear_s && skel_busy_in && (dropped_r != 16'hFFFF)) begin
      dropped_r <= dropped_r + 16'h0001;
    end
  end

  assign frames_dropped_out = dropped_r;
`else
  assign frames_dropped_out = 16'h0000;
`endif

endmodule
